// File: rtl/special_case_detector_for_divider.sv
// ============================================================================
// Module   : special_case_detector_for_divider
// Brief    : HUB divider front-end that classifies X/Y special cases and
//            buffers the operands and codes in a 2-entry FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module special_case_detector_for_divider #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7,
    parameter int CNT_W        = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [E+M:0]                     X,
    input  logic [E+M:0]                     Y,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [E+M:0]                     X_out,
    output logic [E+M:0]                     Y_out,
    output logic [$clog2(special_case)-1:0]  X_special_case,
    output logic [$clog2(special_case)-1:0]  Y_special_case,
    output logic                             is_special,
    output logic [CNT_W-1:0]                 special_count
);

    localparam int CW = $clog2(special_case);

    localparam logic [CW-1:0] C_NONE   = CW'(0);
    localparam logic [CW-1:0] C_INF_P  = CW'(1);
    localparam logic [CW-1:0] C_INF_N  = CW'(2);
    localparam logic [CW-1:0] C_ZERO_P = CW'(3);
    localparam logic [CW-1:0] C_ZERO_N = CW'(4);
    localparam logic [CW-1:0] C_ONE_P  = CW'(5);
    localparam logic [CW-1:0] C_ONE_N  = CW'(6);

    // HUB encoding of 1.0: biased exponent is the top bit alone, mantissa zero
    localparam logic [E-1:0] C_EXP_ONE = {1'b1, {(E-1){1'b0}}};

    function automatic logic [CW-1:0] classify(input logic [E+M:0] v);
        logic         s;
        logic [E-1:0] ex;
        logic [M-1:0] mn;
        s  = v[E+M];
        ex = v[E+M-1:M];
        mn = v[M-1:0];
        classify = C_NONE;
        if ((&ex) && (&mn)) begin
            classify = s ? C_INF_N : C_INF_P;
        end else if ((ex == '0) && (mn == '0)) begin
            classify = s ? C_ZERO_N : C_ZERO_P;
        end else if ((ex == C_EXP_ONE) && (mn == '0)) begin
            classify = s ? C_ONE_N : C_ONE_P;
        end
    endfunction

    logic [E+M:0]     x_q  [2];
    logic [E+M:0]     y_q  [2];
    logic [CW-1:0]    xc_q [2];
    logic [CW-1:0]    yc_q [2];
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] spc_q, spc_d;

    logic w_push;
    logic w_pop;

    assign in_ready       = (cnt_q != 2'd2);
    assign out_valid      = (cnt_q != 2'd0);
    assign w_push         = in_valid & in_ready;
    assign w_pop          = out_valid & out_ready;

    assign X_out          = x_q[rd_q];
    assign Y_out          = y_q[rd_q];
    assign X_special_case = xc_q[rd_q];
    assign Y_special_case = yc_q[rd_q];
    assign is_special     = (X_special_case != C_NONE) | (Y_special_case != C_NONE);
    assign special_count  = spc_q;

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        spc_d = spc_q;
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (w_pop && !w_push) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (w_push) begin
            wr_d = ~wr_q;
        end
        if (w_pop) begin
            rd_d = ~rd_q;
            if (is_special && !(&spc_q)) begin
                spc_d = spc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            spc_q <= '0;
            for (int i = 0; i < 2; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                xc_q[i] <= '0;
                yc_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            spc_q <= spc_d;
            // Codes are captured with the operands so the head never needs reclassifying
            if (w_push) begin
                x_q[wr_q]  <= X;
                y_q[wr_q]  <= Y;
                xc_q[wr_q] <= classify(X);
                yc_q[wr_q] <= classify(Y);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/special_case_detector_for_divider.md
# special_case_detector_for_divider

Registered front-end of the HUB floating-point divider. It accepts an operand pair (X, Y) over a valid/ready handshake and classifies each operand into the divider's 3-bit special-case code (NONE, ±inf, ±0, ±1). It forwards the operands and codes through a 2-entry buffer to the datapath and to the special-result selector, which consumes these codes. It also keeps a saturating count of special-case operations delivered.

## Interface
- M, 23, mantissa width
- E, 8, exponent width
- special_case, 7, number of case codes including NONE; code width CW = $clog2(special_case)
- CNT_W, 16, width of special-operation counter

- clk  input  1  clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operand pair X/Y valid
- in_ready  output  1  block can accept a pair
- X  input  E+M+1  dividend, HUB format {sign, exp, mant}
- Y  input  E+M+1  divisor
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- X_out  output  E+M+1  buffered X
- Y_out  output  E+M+1  buffered Y
- X_special_case  output  CW  code of X_out
- Y_special_case  output  CW  code of Y_out
- is_special  output  1  X_special_case != 0 or Y_special_case != 0
- special_count  output  CNT_W  number of delivered entries with is_special=1, saturating

## Operation
- Codes: NONE=0, INF_P=1, INF_N=2, ZERO_P=3, ZERO_N=4, ONE_P=5, ONE_N=6. Code 7 is never produced.
- Classification of operand V, sign s = V[E+M], exp = V[E+M-1:M], mant = V[M-1:0], in priority order:
  - exp all-ones and mant all-ones -> INF (P if s=0, N if s=1).
  - exp zero and mant zero -> ZERO.
  - exp = {1'b1, (E-1) zeros} and mant zero -> ONE.
  - everything else, including all-ones exp with other mantissa values, -> NONE.
- Classification is combinational on X/Y at the input. The code is stored with the operands at acceptance and never recomputed from the buffered copy.
- Buffer: 2-entry FIFO with registered state: entries[0:1], read pointer, write pointer, count 0..2.
- in_ready = (count != 2). It depends only on registered state, never on out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (count != 0). Outputs are driven from the head entry. Output values are don't-care but stable when out_valid=0; they are driven from the head slot.
- Count update:
  - push & ~pop: +1
  - pop & ~push: −1
  - both: unchanged
- Pointers are 1 bit and wrap 1 -> 0.
- special_count increments on pop when is_special=1 and holds at 2^CNT_W−1.
- Non-handshake cycles leave all state unchanged. A held in_valid with changing X/Y before acceptance is legal; only the value present at the accepting edge is stored.

## Timing
- Reset (asynchronous assert, rst_n low), all outputs:
  - count=0 and pointers=0.
  - out_valid=0, in_ready=1.
  - special_count=0.
  - X_out/Y_out/codes=0 (entries cleared), is_special=0.
- Release is synchronous to clk. The first push is possible at the first rising edge with rst_n high.
- Latency 1: a pair accepted at edge k is on the outputs with out_valid=1 from edge k through the edge of its pop.
- Throughput: 1 pair/cycle with out_ready held high. count stays ≤1 in that case.
- Backpressure: with out_ready=0, two pairs are accepted and in_ready drops after the second edge. One pop re-raises in_ready at the next edge.
- Full (count=2) with pop: in_ready=0 blocks push, so count becomes 1.
- Empty (count=0) with push: out_valid rises next edge. No combinational bypass from input to output.
- Reset mid-operation: buffered entries are discarded, special_count is cleared, and nothing is delivered.

## Test plan
- Classification sweep (M=23, E=8), each single pair, out_ready=1:
  - 0x7FFFFFFF->1, 0xFFFFFFFF->2, 0x00000000->3, 0x80000000->4, 0x40000000->5, 0xC0000000->6.
  - 0x3F800000->0, 0x7F800000->0.
  - Codes appear one cycle after acceptance, and is_special matches.
- Throughput: stream 10 pairs with in_valid=1, out_ready=1 -> one output per cycle, order preserved, in_ready stays 1, count ≤1.
- Backpressure: out_ready=0, offer 3 pairs -> first two accepted, in_ready=0 on the third. Then raise out_ready -> outputs arrive in order A, B, C, none lost or duplicated.
- Simultaneous push/pop at count=1 -> count stays 1, head advances to the new entry next cycle.
- Counter: CNT_W=4, deliver 20 pairs with X=0x7FFFFFFF -> special_count reaches 15 and holds. NONE/NONE pairs do not increment.
- Reset mid-operation: fill to count=2, assert rst_n low between edges -> out_valid=0, in_ready=1, special_count=0 immediately. After release the old entries never appear.
